// File: rtl/icache_refill_ctrl.sv
// L1 I-cache line refill sequencer: one line-aligned memory request per miss,
// beat write-back into the data array, critical-word forward, tag write on completion.
module icache_refill_ctrl #(
  parameter int unsigned ADDR       = 32,
  parameter int unsigned INST       = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          miss_valid,
  input  logic [ADDR-1:0]               miss_addr,
  output logic                          miss_ready,
  output logic                          busy,
  input  logic                          flush,
  output logic                          mem_req_valid,
  output logic [ADDR-1:0]               mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
  input  logic [INST-1:0]               mem_resp_data,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [INST-1:0]               fill_data,
  output logic [ADDR-1:0]               fill_addr,
  output logic                          tag_we,
  output logic                          fwd_valid,
  output logic [INST-1:0]               fwd_data
);

  localparam int unsigned IDXW = $clog2(LINE_WORDS);
  localparam int unsigned OFF  = IDXW + 2;
  localparam logic [IDXW-1:0] LAST = IDXW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DRAIN} state_e;

  state_e          state_q;
  logic [IDXW-1:0] cnt_q;
  logic [IDXW-1:0] crit_q;
  logic [ADDR-1:0] base_q;
  logic            last_beat;
  logic            beat_write;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[1:0];
  assign last_beat        = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crit_q  <= '0;
      base_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_valid && !flush) begin
            base_q  <= {miss_addr[ADDR-1:OFF], {OFF{1'b0}}};
            crit_q  <= miss_addr[OFF-1:2];
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          // A handshake coinciding with flush still owes us a full line of beats.
          if (mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= flush ? S_DRAIN : S_FILL;
          end else if (flush) begin
            state_q <= S_IDLE;
          end
        end
        S_FILL: begin
          if (mem_resp_valid) begin
            cnt_q <= cnt_q + IDXW'(1);
            if (last_beat)  state_q <= S_IDLE;
            else if (flush) state_q <= S_DRAIN;
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_resp_valid) begin
            cnt_q <= cnt_q + IDXW'(1);
            if (last_beat) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    miss_ready    = !busy;
    mem_req_valid = (state_q == S_REQ);
    mem_req_addr  = mem_req_valid ? base_q : '0;
    fill_addr     = busy ? base_q : '0;

    beat_write = (state_q == S_FILL) && mem_resp_valid && !flush;
    fill_we    = beat_write;
    fill_idx   = beat_write ? cnt_q : '0;
    fill_data  = beat_write ? mem_resp_data : '0;
    fwd_valid  = beat_write && (cnt_q == crit_q);
    fwd_data   = fwd_valid ? mem_resp_data : '0;
    tag_we     = beat_write && last_beat;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: directed refill scenarios push expected
// requests/beats/forwards/tag writes; a negedge monitor pops and compares.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset, miss_valid, flush, mem_req_ready, mem_resp_valid;
  logic [31:0] miss_addr, mem_resp_data;
  logic        miss_ready, busy, mem_req_valid, fill_we, tag_we, fwd_valid;
  logic [31:0] mem_req_addr, fill_data, fill_addr, fwd_data;
  logic [1:0]  fill_idx;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_req_q[$];
  logic [1:0]  exp_idx_q[$];
  logic [31:0] exp_fill_q[$];
  logic [31:0] exp_fwd_q[$];
  logic [31:0] exp_tag_q[$];

  icache_refill_ctrl #(.ADDR(32), .INST(32), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .busy(busy), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .fill_addr(fill_addr),
    .tag_we(tag_we), .fwd_valid(fwd_valid), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] a);
    miss_valid = 1'b1;
    miss_addr  = a;
    step();
    miss_valid = 1'b0;
  endtask

  task automatic req_hs();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic fl);
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    flush          = fl;
    step();
    mem_resp_valid = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic expect_line(input logic [31:0] base, input logic [31:0] d0, input int unsigned crit);
    exp_req_q.push_back(base);
    for (int unsigned i = 0; i < 4; i++) begin
      exp_idx_q.push_back(2'(i));
      exp_fill_q.push_back(d0 + i);
    end
    exp_fwd_q.push_back(d0 + crit);
    exp_tag_q.push_back(base);
  endtask

  // Monitor: every observed event must match the head of its expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req_q.size() == 0) check("unexpected_req", mem_req_addr, 32'hDEAD_BEEF);
        else check("req_addr", mem_req_addr, exp_req_q.pop_front());
      end
      if (fill_we) begin
        if (exp_fill_q.size() == 0) check("unexpected_fill", fill_data, 32'hDEAD_BEEF);
        else begin
          check("fill_idx", 32'(fill_idx), 32'(exp_idx_q.pop_front()));
          check("fill_data", fill_data, exp_fill_q.pop_front());
        end
      end
      if (fwd_valid) begin
        if (exp_fwd_q.size() == 0) check("unexpected_fwd", fwd_data, 32'hDEAD_BEEF);
        else check("fwd_data", fwd_data, exp_fwd_q.pop_front());
      end
      if (tag_we) begin
        if (exp_tag_q.size() == 0) check("unexpected_tag", fill_addr, 32'hDEAD_BEEF);
        else check("tag_addr", fill_addr, exp_tag_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; miss_valid = 1'b0; flush = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; miss_addr = '0; mem_resp_data = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_miss_ready", 32'(miss_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_valid", 32'(mem_req_valid), 0);
    check("rst_fill_addr", fill_addr, 0);
    step();

    // Basic back-to-back refill, critical word 2
    expect_line(32'h1000, 32'hA000_0000, 2);
    do_miss(32'h1008);
    check("req_valid_t1", 32'(mem_req_valid), 1);
    check("req_addr_t1", mem_req_addr, 32'h1000);
    req_hs();
    for (int unsigned i = 0; i < 4; i++) beat(32'hA000_0000 + i, 1'b0);
    check("basic_ready_after", 32'(miss_ready), 1);
    step();

    // Gapped response
    expect_line(32'h1000, 32'hB000_0000, 2);
    do_miss(32'h1008);
    req_hs();
    for (int unsigned i = 0; i < 4; i++) begin
      beat(32'hB000_0000 + i, 1'b0);
      if (i < 3) begin
        step();
        check("gap_busy", 32'(busy), 1);
        check("gap_fill_addr", fill_addr, 32'h1000);
        step();
      end
    end
    check("gap_ready_after", 32'(miss_ready), 1);

    // Flush in REQ without handshake, then a fresh miss
    do_miss(32'h3004);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("reqflush_ready", 32'(miss_ready), 1);
    check("reqflush_req_valid", 32'(mem_req_valid), 0);
    expect_line(32'h2000, 32'hC000_0000, 0);
    do_miss(32'h2000);
    req_hs();
    for (int unsigned i = 0; i < 4; i++) beat(32'hC000_0000 + i, 1'b0);
    check("c_ready_after", 32'(miss_ready), 1);

    // Flush on beat 1: only beat 0 written, rest drained
    exp_req_q.push_back(32'h4000);
    exp_idx_q.push_back(2'd0);
    exp_fill_q.push_back(32'hD000_0000);
    do_miss(32'h4004);
    req_hs();
    beat(32'hD000_0000, 1'b0);
    beat(32'hD000_0001, 1'b1);
    check("drain_busy", 32'(busy), 1);
    beat(32'hD000_0002, 1'b1);
    check("drain_busy2", 32'(busy), 1);
    beat(32'hD000_0003, 1'b0);
    check("drain_ready_after", 32'(miss_ready), 1);

    // Miss and flush together in IDLE
    miss_valid = 1'b1; miss_addr = 32'h5000; flush = 1'b1;
    step();
    miss_valid = 1'b0; flush = 1'b0;
    #1;
    check("missflush_ready", 32'(miss_ready), 1);
    check("missflush_busy", 32'(busy), 0);
    check("missflush_req_valid", 32'(mem_req_valid), 0);

    // Flush coinciding with request handshake drains the whole line
    exp_req_q.push_back(32'h7000);
    do_miss(32'h700C);
    mem_req_ready = 1'b1; flush = 1'b1;
    step();
    mem_req_ready = 1'b0; flush = 1'b0;
    check("hsflush_busy", 32'(busy), 1);
    for (int unsigned i = 0; i < 3; i++) beat(32'h7700_0000 + i, 1'b0);
    check("hsflush_busy3", 32'(busy), 1);
    beat(32'h7700_0003, 1'b0);
    check("hsflush_ready", 32'(miss_ready), 1);

    // Reset mid-fill after two beats, then a clean refill from word 0
    exp_req_q.push_back(32'h5000);
    exp_idx_q.push_back(2'd0); exp_fill_q.push_back(32'hE000_0000);
    exp_idx_q.push_back(2'd1); exp_fill_q.push_back(32'hE000_0001);
    do_miss(32'h5008);
    req_hs();
    beat(32'hE000_0000, 1'b0);
    beat(32'hE000_0001, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_ready", 32'(miss_ready), 1);
    check("midrst_busy", 32'(busy), 0);
    expect_line(32'h6000, 32'hF000_0000, 3);
    do_miss(32'h600C);
    req_hs();
    for (int unsigned i = 0; i < 4; i++) beat(32'hF000_0000 + i, 1'b0);
    check("f_ready_after", 32'(miss_ready), 1);

    step(); step();
    check("req_q_empty", 32'(exp_req_q.size()), 0);
    check("fill_q_empty", 32'(exp_fill_q.size()), 0);
    check("fwd_q_empty", 32'(exp_fwd_q.size()), 0);
    check("tag_q_empty", 32'(exp_tag_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
